// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime baud divisor, optional even/odd parity,
// per-frame error flags, and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           par_mode,
  input  logic                 rd_en,
  input  logic                 clr_ovr,
  output logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } entry_t;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [1:0]           par_q, par_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pacc_q, pacc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 push;

  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 ovr_q;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               head;
  logic                 full, pop, push_ok;

  logic                 par_on, bit_tick;
  logic [DIV_W-1:0]     half_div;

  assign par_on   = (par_q == 2'b01) || (par_q == 2'b10);
  assign half_div = div_q >> 1;
  assign bit_tick = (cnt_q == div_q - DIV_W'(1));

  // rx_prev_q tracks rx_s continuously, so a line that stays low after a frame
  // must go high again before another start edge can be seen.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      par_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pacc_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pacc_q    <= pacc_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    par_d   = par_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pacc_d  = pacc_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          div_d   = baud_div;
          par_d   = par_mode;
          cnt_d   = DIV_W'(1);  // the detect cycle is the first half-bit clock
          bit_d   = '0;
          pacc_d  = 1'b0;
          perr_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_div - DIV_W'(1)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          pacc_d  = pacc_q ^ rx_s_q;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = par_on ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          perr_d  = (pacc_q ^ rx_s_q) != par_q[1];  // odd mode expects a 1
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d   = '0;
          ferr_d  = ~rx_s_q;
          state_d = S_PUSH;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = rd_en && (count_q != '0);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
      ovr_q   <= (ovr_q && !clr_ovr) || (push && full && !pop);
    end
  end

  // NOTE: storage is left unreset; outputs are gated by rx_rdy so stale
  // entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {shift_q, ferr_q, perr_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_rdy     = (count_q != '0);
  assign rx_data    = rx_rdy ? head.data : '0;
  assign frame_err  = rx_rdy ? head.ferr : 1'b0;
  assign parity_err = rx_rdy ? head.perr : 1'b0;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8-bit instance for framing, parity and
// FIFO behaviour, and a 7-bit instance with a fast divisor for reset recovery.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, rx8, rd8, clr8, rdy8, fe8, pe8, ovr8;
  logic [15:0] div8;
  logic [1:0]  pm8;
  logic [7:0]  data8;

  logic        rst7_n, rx7, rd7, clr7, rdy7, fe7, pe7, ovr7;
  logic [15:0] div7;
  logic [1:0]  pm7;
  logic [6:0]  data7;

  uart_rx_cfg #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .rx(rx8), .baud_div(div8), .par_mode(pm8),
    .rd_en(rd8), .clr_ovr(clr8), .rx_rdy(rdy8), .rx_data(data8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ovr8)
  );

  uart_rx_cfg #(.DATA_BITS(7), .DIV_W(16), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst_n(rst7_n), .rx(rx7), .baud_div(div7), .par_mode(pm7),
    .rd_en(rd7), .clr_ovr(clr7), .rx_rdy(rdy7), .rx_data(data7),
    .frame_err(fe7), .parity_err(pe7), .overrun(ovr7)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Cycle count at which rx_rdy of the 8-bit instance last rose.
  int   rise8 = -1;
  logic rdy8_prev = 1'b0;
  always @(negedge clk) begin
    if (rdy8 && !rdy8_prev) rise8 = cyc;
    rdy8_prev = rdy8;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    bit         par_en;
    logic       par_bit;
    int         div;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx8 = v;
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int div);
    set_rx(sel, v);
    repeat (div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input int div, input bit par_en, input logic par_bit,
                            input logic stop_bit, output int start);
    @(posedge clk);
    #1;
    start = cyc;
    drive_bit(sel, 1'b0, div);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], div);
    if (par_en) drive_bit(sel, par_bit, div);
    drive_bit(sel, stop_bit, div);
  endtask

  // Expected cycles from the rx falling edge to the first cycle rx_rdy is high.
  function automatic int latency(input int div, input int nbits, input bit par_en);
    return div / 2 + 3 + (nbits + (par_en ? 1 : 0) + 1) * div;
  endfunction

  task automatic pop_check(input bit sel, input string name, input logic [7:0] exp_data,
                           input logic exp_fe, input logic exp_pe);
    @(negedge clk);
    if (sel) begin
      check({name, ".rdy"}, rdy7, 1'b1);
      check({name, ".data"}, data7, exp_data);
      check({name, ".ferr"}, fe7, exp_fe);
      check({name, ".perr"}, pe7, exp_pe);
      rd7 = 1'b1;
    end else begin
      check({name, ".rdy"}, rdy8, 1'b1);
      check({name, ".data"}, data8, exp_data);
      check({name, ".ferr"}, fe8, exp_fe);
      check({name, ".perr"}, pe8, exp_pe);
      rd8 = 1'b1;
    end
    @(posedge clk);
    #1;
    rd7 = 1'b0;
    rd8 = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2;
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 2604, 1'b0};
    vecs[1] = '{8'hE7, 2'b00, 1'b0, 1'b0, 16,   1'b0};
    vecs[2] = '{8'h24, 2'b00, 1'b0, 1'b0, 16,   1'b0};
    vecs[3] = '{8'h5A, 2'b01, 1'b1, 1'b0, 16,   1'b0};
    vecs[4] = '{8'h5A, 2'b01, 1'b1, 1'b1, 16,   1'b1};
    vecs[5] = '{8'h5B, 2'b10, 1'b1, 1'b0, 16,   1'b0};
    vecs[6] = '{8'h5B, 2'b10, 1'b1, 1'b1, 16,   1'b1};
    vecs[7] = '{8'h81, 2'b11, 1'b0, 1'b0, 16,   1'b0};

    rst_n = 1'b0; rst7_n = 1'b0;
    rx8 = 1'b1; rd8 = 1'b0; clr8 = 1'b0; div8 = 16'd16; pm8 = 2'b00;
    rx7 = 1'b1; rd7 = 1'b0; clr7 = 1'b0; div7 = 16'd8;  pm7 = 2'b00;
    repeat (2) @(negedge clk);
    check("rst.rdy", rdy8, 1'b0);
    check("rst.data", data8, 8'h00);
    check("rst.flags", {fe8, pe8, ovr8}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1; rst7_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Framing and parity table, one frame at a time with exact latency.
    foreach (vecs[i]) begin
      div8 = 16'(vecs[i].div);
      pm8  = vecs[i].pm;
      rise8 = -1;
      send_frame(1'b0, {1'b0, vecs[i].data}, 8, vecs[i].div, vecs[i].par_en,
                 vecs[i].par_bit, 1'b1, s);
      drive_bit(1'b0, 1'b1, vecs[i].div);
      check($sformatf("vec%0d.latency", i), rise8 - s, latency(vecs[i].div, 8, vecs[i].par_en));
      pop_check(1'b0, $sformatf("vec%0d", i), vecs[i].data, 1'b0, vecs[i].exp_perr);
      @(negedge clk);
      check($sformatf("vec%0d.empty", i), rdy8, 1'b0);
    end

    // Stop bit low, then line held low: exactly one frame with frame_err.
    div8 = 16'd16; pm8 = 2'b00;
    send_frame(1'b0, 9'h03C, 8, 16, 1'b0, 1'b0, 1'b0, s);
    repeat (48) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    pop_check(1'b0, "break", 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("break.no_retrigger", rdy8, 1'b0);

    // Quarter-bit glitch is a false start; the next frame still lands on time.
    @(posedge clk);
    #1;
    rx8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("glitch.no_push", rdy8, 1'b0);
    rise8 = -1;
    send_frame(1'b0, 9'h096, 8, 16, 1'b0, 1'b0, 1'b1, s);
    drive_bit(1'b0, 1'b1, 16);
    check("glitch.recover_latency", rise8 - s, latency(16, 8, 1'b0));
    pop_check(1'b0, "glitch.recover", 8'h96, 1'b0, 1'b0);

    // Overrun: fifth frame dropped, contents kept, sticky flag cleared by clr_ovr.
    for (int i = 1; i <= 5; i++) begin
      send_frame(1'b0, 9'(i), 8, 16, 1'b0, 1'b0, 1'b1, s);
      drive_bit(1'b0, 1'b1, 16);
    end
    @(negedge clk);
    check("ovr.set", ovr8, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check(1'b0, $sformatf("ovr.pop%0d", i), 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    check("ovr.drained", rdy8, 1'b0);
    check("ovr.sticky", ovr8, 1'b1);
    clr8 = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
    @(negedge clk);
    check("ovr.cleared", ovr8, 1'b0);

    // Full FIFO with a pop on the push edge: no overrun, fifth frame kept.
    for (int i = 1; i <= 4; i++) begin
      send_frame(1'b0, 9'(i), 8, 16, 1'b0, 1'b0, 1'b1, s);
      drive_bit(1'b0, 1'b1, 16);
    end
    fork
      send_frame(1'b0, 9'h005, 8, 16, 1'b0, 1'b0, 1'b1, s);
      begin
        @(posedge clk);
        #1;
        repeat (latency(16, 8, 1'b0) - 1) @(posedge clk);
        #1;
        rd8 = 1'b1;
        @(posedge clk);
        #1;
        rd8 = 1'b0;
      end
    join
    drive_bit(1'b0, 1'b1, 16);
    @(negedge clk);
    check("ovr2.none", ovr8, 1'b0);
    for (int i = 2; i <= 5; i++) pop_check(1'b0, $sformatf("ovr2.pop%0d", i), 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    check("ovr2.drained", rdy8, 1'b0);

    // 7-bit instance: rd_en on an empty FIFO at the push edge is ignored.
    fork
      send_frame(1'b1, 9'h055, 7, 8, 1'b0, 1'b0, 1'b1, s2);
      begin
        @(posedge clk);
        #1;
        repeat (latency(8, 7, 1'b0) - 1) @(posedge clk);
        #1;
        rd7 = 1'b1;
        @(posedge clk);
        #1;
        rd7 = 1'b0;
      end
    join
    drive_bit(1'b1, 1'b1, 8);
    @(negedge clk);
    check("b7.first_rdy", rdy7, 1'b1);
    check("b7.first_data", data7, 7'h55);
    check("b7.first_ferr", fe7, 1'b0);

    // Reset midway through a second frame empties the FIFO.
    @(posedge clk);
    #1;
    rx7 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst7_n = 1'b0;
    #2;
    check("b7.rst_rdy", rdy7, 1'b0);
    check("b7.rst_data", data7, 7'h00);
    check("b7.rst_flags", {fe7, pe7, ovr7}, 3'b000);
    rx7 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst7_n = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("b7.post_rst_empty", rdy7, 1'b0);
    send_frame(1'b1, 9'h02A, 7, 8, 1'b0, 1'b0, 1'b1, s2);
    drive_bit(1'b1, 1'b1, 8);
    pop_check(1'b1, "b7.after_rst", 8'h2A, 1'b0, 1'b0);
    @(negedge clk);
    check("b7.final_empty", rdy7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
